// File: rtl/dac_channel_scheduler_if.sv
// Voice-side bundle of the DAC scheduler: level requests, channel mask, packed samples,
// and the per-channel ack plus the command word handed to the SPI shifter.
interface dac_channel_scheduler_if;
  logic [3:0]  req;
  logic [3:0]  ch_enable;
  logic [63:0] sample_data;
  logic [3:0]  ack;
  logic [23:0] dac_data;
  logic        send;
  logic        busy;

  modport master (
    output req, ch_enable, sample_data,
    input  ack, dac_data, send, busy
  );

  modport slave (
    input  req, ch_enable, sample_data,
    output ack, dac_data, send, busy
  );
endinterface

// File: rtl/dac_channel_scheduler.sv
// Round-robin arbiter sharing one four-channel SPI DAC among four voices: grants a request,
// builds the 24-bit command word, pulses send, then holds off for one SPI frame.
module dac_channel_scheduler #(
  parameter int unsigned SPI_FRAME_CYCLES = 64,
  parameter logic [3:0]  CMD_PREFIX       = 4'b0011
) (
  input  logic                    clock_in,
  input  logic                    rstn,
  dac_channel_scheduler_if.slave  bus
);

  localparam int unsigned TIMER_W = (SPI_FRAME_CYCLES > 2) ? $clog2(SPI_FRAME_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t               state_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [1:0]           rr_last_reg;
  logic [3:0]           ack_reg;
  logic [23:0]          dac_data_reg;
  logic                 send_reg;
  logic                 busy_reg;

  logic [3:0]           elig;
  logic [1:0]           cand_idx [4];
  logic [3:0]           cand_hit;
  logic                 grant_valid;
  logic [1:0]           grant_idx;
  logic [15:0]          grant_sample;

  assign elig = bus.req & bus.ch_enable;

  // Candidate gi is the channel gi+1 places after the last winner, so slot 0 is highest priority.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = rr_last_reg + 2'(gi + 1);
      assign cand_hit[gi] = elig[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_valid = |cand_hit;
    grant_idx   = cand_idx[3];
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) begin
        grant_idx = cand_idx[i];
      end
    end
  end

  assign grant_sample = bus.sample_data[16*grant_idx +: 16];

  always_ff @(posedge clock_in) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      rr_last_reg  <= 2'd3;
      ack_reg      <= '0;
      dac_data_reg <= '0;
      send_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          send_reg <= 1'b0;
          if (grant_valid) begin
            dac_data_reg <= {CMD_PREFIX, 4'(4'b0001 << grant_idx), grant_sample};
            ack_reg      <= 4'(4'b0001 << grant_idx);
            busy_reg     <= 1'b1;
            rr_last_reg  <= grant_idx;
            state_reg    <= SEND;
          end else begin
            ack_reg  <= '0;
            busy_reg <= 1'b0;
          end
        end
        SEND: begin
          ack_reg   <= '0;
          send_reg  <= 1'b1;
          timer_reg <= TIMER_W'(SPI_FRAME_CYCLES - 1);
          state_reg <= WAIT;
        end
        WAIT: begin
          send_reg <= 1'b0;
          // Frame hold-off: leaves WAIT N edges after the send pulse.
          if (timer_reg == '0) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = ack_reg;
  assign bus.dac_data = dac_data_reg;
  assign bus.send     = send_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Bench for dac_channel_scheduler: a cycle-offset model of the grant/frame timeline checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_dac_channel_scheduler;
  localparam int N = 64;
  localparam int PERIOD = N + 2;

  logic clock_in = 1'b0;
  logic rstn;
  always #5 clock_in = ~clock_in;

  dac_channel_scheduler_if bus();

  dac_channel_scheduler #(
    .SPI_FRAME_CYCLES(N),
    .CMD_PREFIX      (4'b0011)
  ) dut (
    .clock_in(clock_in),
    .rstn    (rstn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: cycles elapsed since the last grant (-1 = free to grant).
  int          m_since = -1;
  int          m_rr = 3;
  logic [3:0]  m_ack = '0;
  logic        m_send = 1'b0;
  logic        m_busy = 1'b0;
  logic [23:0] m_data = '0;

  logic [3:0]  drop_mask;
  int          grant_cyc[$];
  int          grant_ch[$];
  logic [23:0] grant_data[$];
  int          send_cyc[$];
  int          busy_fall;
  int          busy_cycles;
  logic        prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_edge();
    logic [3:0]  elig;
    logic [63:0] shifted;
    int          g;
    if (!rstn) begin
      m_since = -1; m_rr = 3; m_ack = '0; m_send = 1'b0; m_busy = 1'b0; m_data = '0;
    end else if (m_since < 0) begin
      elig = bus.req & bus.ch_enable;
      m_ack = '0; m_send = 1'b0; m_busy = 1'b0;
      g = -1;
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && elig[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      end
      if (g >= 0) begin
        shifted = bus.sample_data >> (16 * g);
        m_ack   = 4'(1 << g);
        m_busy  = 1'b1;
        m_data  = {4'b0011, 4'(1 << g), shifted[15:0]};
        m_rr    = g;
        m_since = 0;
      end
    end else begin
      m_since++;
      m_ack  = '0;
      m_send = (m_since == 1);
      if (m_since == N + 1) begin
        m_busy  = 1'b0;
        m_since = -1;
      end
    end
  endfunction

  task automatic step();
    @(posedge clock_in);
    model_edge();
    #1;
    cyc++;
    checks++;
    if ({bus.ack, bus.send, bus.busy, bus.dac_data} !== {m_ack, m_send, m_busy, m_data}) begin
      errors++;
      $display("FAIL model cycle %0d: ack=%b send=%b busy=%b data=%h required ack=%b send=%b busy=%b data=%h",
               cyc, bus.ack, bus.send, bus.busy, bus.dac_data, m_ack, m_send, m_busy, m_data);
    end
    if (bus.ack != 4'b0000) begin
      grant_cyc.push_back(cyc);
      grant_ch.push_back(($countones(bus.ack) == 1) ? $clog2(bus.ack) : -1);
      grant_data.push_back(bus.dac_data);
    end
    if (bus.send) send_cyc.push_back(cyc);
    if (prev_busy && !bus.busy) busy_fall = cyc;
    if (bus.busy) busy_cycles++;
    prev_busy = bus.busy;
    @(negedge clock_in);
    bus.req = bus.req & ~(bus.ack & drop_mask);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    grant_cyc.delete(); grant_ch.delete(); grant_data.delete(); send_cyc.delete();
    busy_fall = -1; busy_cycles = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    run(2);
    rstn = 1'b1;
    clear_logs();
  endtask

  logic [23:0] exp3 [4];

  initial begin
    rstn = 1'b0;
    bus.req = '0;
    bus.ch_enable = 4'hF;
    bus.sample_data = '0;
    drop_mask = 4'hF;
    clear_logs();

    // 1: reset state
    run(2);
    chk("reset_ack", 32'(bus.ack), 32'h0);
    chk("reset_send", 32'(bus.send), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_data", 32'(bus.dac_data), 32'h000000);
    rstn = 1'b1;
    clear_logs();

    // 2: single request, sample change after grant must not alter the frame
    bus.sample_data[15:0] = 16'h1234;
    bus.req = 4'b0001;
    run(1);
    chk("t2_ack", 32'(bus.ack), 32'h1);
    chk("t2_data", 32'(bus.dac_data), 32'h311234);
    bus.sample_data[15:0] = 16'hFFFF;
    run(80);
    chk("t2_grants", 32'(grant_cyc.size()), 32'd1);
    chk("t2_sends", 32'(send_cyc.size()), 32'd1);
    if (send_cyc.size() > 0 && grant_cyc.size() > 0)
      chk("t2_send_lat", 32'(send_cyc[0] - grant_cyc[0]), 32'd1);
    if (grant_cyc.size() > 0)
      chk("t2_busy_fall", 32'(busy_fall - grant_cyc[0]), 32'd65);

    // 3: all four requesting, one grant per frame in channel order
    do_reset();
    bus.sample_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    bus.req = 4'b1111;
    exp3[0] = 24'h31A000; exp3[1] = 24'h32A001; exp3[2] = 24'h34A002; exp3[3] = 24'h38A003;
    run(4 * PERIOD + 10);
    chk("t3_grants", 32'(grant_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_cyc.size(); i++) begin
      chk($sformatf("t3_ch%0d", i), 32'(grant_ch[i]), 32'(i));
      chk($sformatf("t3_data%0d", i), 32'(grant_data[i]), 32'(exp3[i]));
      if (i > 0) chk($sformatf("t3_gap%0d", i), 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd66);
    end

    // 4: two requests held high alternate
    do_reset();
    drop_mask = 4'h0;
    bus.req = 4'b1010;
    run(230);
    bus.req = 4'b0000;
    drop_mask = 4'hF;
    run(70);
    chk("t4_grants", 32'(grant_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_cyc.size(); i++) begin
      chk($sformatf("t4_ch%0d", i), 32'(grant_ch[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
      if (i > 0) chk($sformatf("t4_gap%0d", i), 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd66);
    end

    // 5: masked channel is ignored until enabled
    do_reset();
    bus.ch_enable = 4'b1101;
    bus.req = 4'b0010;
    run(200);
    chk("t5_no_grant", 32'(grant_cyc.size()), 32'd0);
    chk("t5_no_send", 32'(send_cyc.size()), 32'd0);
    chk("t5_no_busy", 32'(busy_cycles), 32'd0);
    bus.ch_enable = 4'hF;
    run(1);
    chk("t5_ack_after_enable", 32'(bus.ack), 32'h2);
    run(70);

    // 6: reset mid-frame aborts, then round-robin restarts at channel 0
    do_reset();
    drop_mask = 4'h0;
    bus.req = 4'b0110;
    for (int i = 0; i < 5 && send_cyc.size() == 0; i++) step();
    chk("t6_first_send", 32'(send_cyc.size()), 32'd1);
    if (grant_ch.size() > 0) chk("t6_pre_ch", 32'(grant_ch[0]), 32'd1);
    run(9);
    rstn = 1'b0;
    step();
    chk("t6_abort_busy", 32'(bus.busy), 32'h0);
    chk("t6_abort_send", 32'(bus.send), 32'h0);
    chk("t6_sends_before_release", 32'(send_cyc.size()), 32'd1);
    rstn = 1'b1;
    clear_logs();
    drop_mask = 4'hF;
    run(140);
    chk("t6_grants", 32'(grant_cyc.size()), 32'd2);
    chk("t6_sends", 32'(send_cyc.size()), 32'd2);
    if (grant_cyc.size() >= 2) begin
      chk("t6_ch_first", 32'(grant_ch[0]), 32'd1);
      chk("t6_ch_second", 32'(grant_ch[1]), 32'd2);
      chk("t6_gap", 32'(grant_cyc[1] - grant_cyc[0]), 32'd66);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
